// File: rtl/inst_rom_resp_pkg.sv
// inst_rom_resp_pkg: shared FSM encoding, reset level and constants for the instruction ROM responder
package inst_rom_resp_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic RST_ENABLE = 1'b0;
   localparam int WCNT_W = 3;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
endpackage

// File: rtl/inst_rom_resp_mem_array.sv
// inst_rom_resp_mem_array: word memory with synchronous read-before-write and one write port
module inst_rom_resp_mem_array #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [31:0]           wr_data
);
   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: fetch responder returning a memory word after WAIT_CYCLES wait states, stalling the PC meanwhile
module inst_rom_resp
   import inst_rom_resp_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_i,
   input  logic [31:0]           pc_i,
   output logic [31:0]           inst_o,
   output logic                  inst_valid_o,
   output logic                  stall_req_o,
   output logic                  misalign_o,
   input  logic                  wr_en_i,
   input  logic [DEPTH_LOG2-1:0] wr_addr_i,
   input  logic [31:0]           wr_data_i
);
   localparam state_t ACC_ST = (WAIT_CYCLES == 0) ? RESP : WAIT;
   localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(WAIT_CYCLES - 1);
   state_t state, nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [DEPTH_LOG2-1:0] idx_r, rd_addr;
   logic mis_r, accept, rd_en, unused_pc;
   logic [31:0] rd_data;
   assign unused_pc = ^pc_i[31:DEPTH_LOG2+2];
   inst_rom_resp_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk(clk),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .wr_en(wr_en_i),
      .wr_addr(wr_addr_i),
      .wr_data(wr_data_i)
   );
   // IDLE and RESP both accept a request; WAIT reads from the captured index
   always_comb begin
      accept = ce_i & (state != WAIT);
      nxt = (state == WAIT) ? (!ce_i ? IDLE : (wcnt == W_LAST) ? RESP : WAIT)
                            : (ce_i ? ACC_ST : IDLE);
      rd_addr = (state == WAIT) ? idx_r : pc_i[DEPTH_LOG2+1:2];
      rd_en = (nxt == RESP) & ((state == WAIT) ? !mis_r : (pc_i[1:0] == 2'b00));
      inst_valid_o = (state == RESP);
      misalign_o = inst_valid_o & mis_r;
      inst_o = !inst_valid_o ? '0 : mis_r ? NOP_INST : rd_data;
      stall_req_o = (rst != RST_ENABLE) & ((state == WAIT) |
                    (ce_i & ((state == IDLE) | ((state == RESP) & (WAIT_CYCLES != 0)))));
   end
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= IDLE;
         wcnt  <= '0;
         idx_r <= '0;
         mis_r <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            idx_r <= pc_i[DEPTH_LOG2+1:2];
            mis_r <= (pc_i[1:0] != 2'b00);
            wcnt  <= '0;
         end else if (state == WAIT) wcnt <= wcnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_inst_rom_resp.sv
// tb_inst_rom_resp: scoreboard bench driving three responders with 0, 1 and 3 wait states
module tb_inst_rom_resp;
   localparam logic [31:0] NOP = 32'h0000_0000;
   logic clk = 1'b0, rst = 1'b0;
   logic ce0 = 1'b0, ce1 = 1'b0, ce3 = 1'b0;
   logic [31:0] pc = 32'h0;
   logic wr_en = 1'b0;
   logic [9:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] inst0, inst1, inst3;
   logic v0, v1, v3, s0, s1, s3, m0, m1, m3;
   logic [31:0] model [0:1023];
   logic [32:0] q0[$], q1[$], q3[$];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   inst_rom_resp #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .ce_i(ce0), .pc_i(pc), .inst_o(inst0),
      .inst_valid_o(v0), .stall_req_o(s0), .misalign_o(m0), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data));
   inst_rom_resp #(.WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .ce_i(ce1), .pc_i(pc), .inst_o(inst1),
      .inst_valid_o(v1), .stall_req_o(s1), .misalign_o(m1), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data));
   inst_rom_resp #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .ce_i(ce3), .pc_i(pc), .inst_o(inst3),
      .inst_valid_o(v3), .stall_req_o(s3), .misalign_o(m3), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic vld(input int w);
      return (w == 0) ? v0 : (w == 1) ? v1 : v3;
   endfunction
   task automatic set_ce(input int w, input logic b);
      if (w == 0) ce0 = b; else if (w == 1) ce1 = b; else ce3 = b;
   endtask
   task automatic push(input int w, input logic [31:0] a);
      logic [32:0] e;
      e = (a[1:0] != 2'b00) ? {1'b1, NOP} : {1'b0, model[a[11:2]]};
      if (w == 0) q0.push_back(e); else if (w == 1) q1.push_back(e); else q3.push_back(e);
   endtask
   task automatic load(input logic [9:0] idx, input logic [31:0] d);
      wr_addr = idx; wr_data = d; wr_en = 1'b1; model[idx] = d;
      @(posedge clk); #1 wr_en = 1'b0;
   endtask
   task automatic single(input int w, input logic [31:0] a, input int lat);
      pc = a; set_ce(w, 1'b1); push(w, a);
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk); check("lat_early", 64'(vld(w)), 0);
         @(posedge clk);
      end
      #1 set_ce(w, 1'b0);
      @(negedge clk); check("lat_on", 64'(vld(w)), 1);
      @(posedge clk); #1;
   endtask
   always @(negedge clk) if (rst) begin
      logic [32:0] e;
      if (v0) begin
         if (q0.size() == 0) check("u0_spurious", 1, 0);
         else begin e = q0.pop_front(); check("u0_inst", {m0, inst0}, 64'(e)); end
      end else check("u0_idle_zero", {m0, inst0}, 0);
   end
   always @(negedge clk) if (rst) begin
      logic [32:0] e;
      if (v1) begin
         if (q1.size() == 0) check("u1_spurious", 1, 0);
         else begin e = q1.pop_front(); check("u1_inst", {m1, inst1}, 64'(e)); end
      end else check("u1_idle_zero", {m1, inst1}, 0);
   end
   always @(negedge clk) if (rst) begin
      logic [32:0] e;
      if (v3) begin
         if (q3.size() == 0) check("u3_spurious", 1, 0);
         else begin e = q3.pop_front(); check("u3_inst", {m3, inst3}, 64'(e)); end
      end else check("u3_idle_zero", {m3, inst3}, 0);
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      ce0 = 1'b1; ce1 = 1'b1; ce3 = 1'b1; pc = 32'h40;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check("rst_u0", {v0, s0, m0, inst0}, 0);
         check("rst_u1", {v1, s1, m1, inst1}, 0);
         check("rst_u3", {v3, s3, m3, inst3}, 0);
      end
      @(posedge clk); #1 ce0 = 1'b0; ce1 = 1'b0; ce3 = 1'b0; rst = 1'b1;
      load(10'd0, 32'h3C01_0001);
      load(10'd1, 32'h3421_0002);
      load(10'd2, 32'h0000_0000);
      load(10'd4, 32'h2442_0003);
      load(10'd5, 32'h1111_2222);
      for (int k = 0; k < 3; k++) begin
         pc = 32'(4 * k); ce1 = 1'b1; push(1, pc);
         @(negedge clk); check("t2_stall_acc", 64'(s1), 1);
         @(posedge clk); @(negedge clk); check("t2_stall_wait", 64'(s1), 1);
         check("t2_no_pulse_in_wait", 64'(v1), 0);
         @(posedge clk); #1;
      end
      ce1 = 1'b0;
      @(negedge clk); check("t2_last_valid", 64'(v1), 1); check("t2_stall_end", 64'(s1), 0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         pc = 32'(4 * k); ce0 = 1'b1; push(0, pc);
         @(negedge clk);
         if (k > 0) begin check("t3_valid", 64'(v0), 1); check("t3_stall", 64'(s0), 0); end
         else check("t3_stall_first", 64'(s0), 1);
         @(posedge clk); #1;
      end
      ce0 = 1'b0;
      @(negedge clk); check("t3_valid_last", 64'(v0), 1); check("t3_stall_last", 64'(s0), 0);
      @(posedge clk); #1;
      single(1, 32'h6, 1);
      single(0, 32'h6, 0);
      single(3, 32'h10, 3);
      pc = 32'h10; ce3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 ce3 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("t5_stall_after_abort", 64'(s3), 0); check("t5_no_valid", 64'(v3), 0);
      repeat (6) @(posedge clk);
      #1 pc = 32'h10; ce3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1; ce3 = 1'b0;
      @(negedge clk); check("rst_mid_stall", 64'(s3), 0);
      repeat (6) @(posedge clk);
      #1 pc = 32'h14; ce1 = 1'b1; push(1, pc);
      @(posedge clk); #1 wr_addr = 10'd5; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
      @(posedge clk); #1 wr_en = 1'b0; ce1 = 1'b0; model[5] = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      single(1, 32'h14, 1);
      single(0, 32'h4, 0);
      repeat (4) @(posedge clk);
      check("q0_drained", 64'(q0.size()), 0);
      check("q1_drained", 64'(q1.size()), 0);
      check("q3_drained", 64'(q3.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
